// File: rtl/tree_accumulator.sv
// Accumulates a programmed number of adder-tree partial sums into one wide result,
// delivered on a valid/ready handshake. Define TREE_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module tree_accumulator #(
    parameter int IDATA_WIDTH = 21,
    parameter int ACC_WIDTH   = 32,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [LEN_WIDTH-1:0]   i_len,
    input  logic                   i_valid,
    input  logic [IDATA_WIDTH-1:0] i_data,
    output logic                   o_in_ready,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [ACC_WIDTH-1:0]   o_data,
    output logic                   o_ovf,
    input  logic                   i_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, data_q, data_d;
    logic                 ovf_q, ovf_d, valid_q, valid_d, res_ovf_q, res_ovf_d;

    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic                 ovf_nxt;

    always_comb begin
        sum     = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - IDATA_WIDTH){1'b0}}, i_data};
        ovf_nxt = ovf_q | sum[ACC_WIDTH];
`ifdef TREE_ACC_SATURATE_EN
        // Once any beat has carried out, the result is pinned at full scale.
        acc_nxt = ovf_nxt ? '1 : sum[ACC_WIDTH-1:0];
`else
        acc_nxt = sum[ACC_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        data_d    = data_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            IDLE: begin
                if (i_start && (i_len != '0)) begin
                    len_d   = i_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    acc_d = acc_nxt;
                    ovf_d = ovf_nxt;
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    // Compare against len-1 so len = 2^LEN_WIDTH-1 never needs cnt to wrap.
                    if (cnt_q == (len_q - LEN_WIDTH'(1))) begin
                        data_d    = acc_nxt;
                        res_ovf_d = ovf_nxt;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign o_in_ready = (state_q == ACCUM);
    assign o_busy     = (state_q != IDLE);
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_ovf      = res_ovf_q;

endmodule

// File: doc/tree_accumulator.md
Name: tree_accumulator

Overview:
- Sits directly downstream of the adder tree.
- Consumes one reduced partial sum per beat and accumulates a programmed number of beats into one wide result, so dot products longer than the tree's input count become possible.
- Presents each finished result on a valid/ready output handshake to the writeback stage.
- Flags overflow of the accumulator width.

Parameters:
IDATA_WIDTH, 21, width of the adder-tree partial sum (tree input width 16 + 5 stages); treated as unsigned
ACC_WIDTH, 32, accumulator and result width; must be >= IDATA_WIDTH
LEN_WIDTH, 16, width of the beat-count field

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_start  input  1  pulse: begin a new accumulation (accepted only in IDLE)
i_len  input  LEN_WIDTH  beats per result, sampled when start is accepted
i_valid  input  1  partial sum on i_data is valid this cycle
i_data  input  IDATA_WIDTH  partial sum from adder tree
o_in_ready  output  1  block accepts i_data this cycle (high only in ACCUM)
o_busy  output  1  state != IDLE
o_valid  output  1  result valid
o_data  output  ACC_WIDTH  accumulated result
o_ovf  output  1  result overflowed ACC_WIDTH; qualified by o_valid
i_ready  input  1  downstream accepts result

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-accumulation): state=IDLE, acc=0, beat count=0, o_valid=0, o_data=0, o_ovf=0, o_in_ready=0, o_busy=0. Any partial result is discarded.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE:
  - i_start=1 with i_len!=0: latch len=i_len, acc=0, cnt=0, ovf=0, go to ACCUM.
  - i_start=1 with i_len==0: ignored, stay in IDLE, no result produced.
  - i_valid is ignored in IDLE.
- ACCUM:
  - o_in_ready=1.
  - Beat accepted when i_valid=1: acc += zero-extended i_data, cnt += 1.
  - A cycle with i_valid=0 is a stall; state is held.
  - On the beat where cnt==len-1:
    - load o_data with the final sum and set o_ovf;
    - o_valid=1 on the next cycle (1-cycle latency from last beat);
    - state goes to HOLD.
  - i_start is ignored in ACCUM.
- HOLD:
  - o_in_ready=0; o_valid, o_data and o_ovf are held stable.
  - When o_valid=1 and i_ready=1 in the same cycle: o_valid=0 next cycle, state goes to IDLE.
  - i_start and i_valid are ignored in HOLD. A start is accepted no earlier than the cycle after the handshake.
- Throughput: one beat per cycle in ACCUM.
  - Minimum result period is len + 2 cycles: start, len beats, handshake.
- Arithmetic:
  - Unsigned addition at ACC_WIDTH+1 bits internally.
  - A carry-out on any beat sets sticky ovf for the current result.
  - Default result on carry-out is the wrapped sum (see optional feature).
- len equal to its maximum value (2^LEN_WIDTH - 1) must work; the counter must not wrap before the last beat.
- len==1: the single accepted beat produces o_data=i_data one cycle later.
- o_busy is combinational from state.

Optional Feature:
- Macro: TREE_ACC_SATURATE_EN.
- Defined: on carry-out, acc clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the accumulation. o_ovf is set as normal.
- Not defined: acc wraps modulo 2^ACC_WIDTH. o_ovf is still set.

Test Plan:
- Basic: len=4, beats 10,20,30,40 with no gaps, i_ready=1 -> o_valid one cycle after the 4th beat, o_data=100, o_ovf=0, back in IDLE the next cycle.
- Stalls and backpressure: len=3, beats 5,_,7,_,_,9 with i_valid gaps, i_ready=0 for 3 cycles -> o_data=21 held stable, o_valid high until i_ready=1, then returns to IDLE.
- Edge lengths:
  - len=0 start -> no state change, o_busy stays 0.
  - len=1, beat 0x1FFFFF -> o_data=0x1FFFFF.
- Overflow, ACC_WIDTH=21 override: len=2, beats 0x1FFFFF,0x000002 -> without macro o_data=0x000001, o_ovf=1; with TREE_ACC_SATURATE_EN o_data=0x1FFFFF, o_ovf=1.
- Ignored inputs: i_start pulsed in ACCUM and HOLD, and i_valid pulsed in IDLE/HOLD -> no effect on len, acc or result. Next start after the handshake begins with acc=0.
- Reset mid-operation: rst asserted after 2 of 4 beats -> all outputs 0, IDLE. New len=2 run with 3,4 -> o_data=7.
